// File: rtl/lock_top_module.sv
// ----------------------------------------------------------------------------
// lock_top_module
//   Six-digit combination checker for the lock subsystem. One BCD digit is
//   sampled on every rising clock edge while entry is enabled.
//
//   The display behaves as follows:
//     - Each correct digit is echoed on the 7-segment display.
//     - A wrong digit shows "E".
//     - Reaching MAX_ERR errors shows "F".
//     - Completing the code shows "S" (no errors) or "P" (one or more errors
//       below MAX_ERR).
//
//   Once a verdict is reached, the block stays in that verdict until reset.
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous active-low reset
//   insere    in   1  1 = hold (digits ignored), 0 = sample entrada each edge
//   entrada   in   4  BCD digit under test (10..15 never match)
//   display1  out  7  registered 7-seg pattern, active-high, {g,f,e,d,c,b,a}
//   led       out  1  registered, 1 only after full success
// ----------------------------------------------------------------------------
module lock_top_module #(
    parameter logic [3:0]  CODE0   = 4'd5,
    parameter logic [3:0]  CODE1   = 4'd9,
    parameter logic [3:0]  CODE2   = 4'd0,
    parameter logic [3:0]  CODE3   = 4'd0,
    parameter logic [3:0]  CODE4   = 4'd6,
    parameter logic [3:0]  CODE5   = 4'd0,
    parameter int unsigned MAX_ERR = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       insere,
    input  logic [3:0] entrada,
    output logic [6:0] display1,
    output logic       led
);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_OK    = 2'd1,
        ST_PART  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam logic [1:0] MAX_ERR_L = 2'(MAX_ERR);
    localparam logic [2:0] LAST_POS  = 3'd5;

    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_F    = 7'h71;
    localparam logic [6:0] SEG_S    = 7'h6D;
    localparam logic [6:0] SEG_P    = 7'h73;

    // Expected digit for a given position.
    // Positions 6 and 7 are unreachable in ENTRY.
    function automatic logic [3:0] code_at(input logic [2:0] p);
        logic [3:0] c;
        case (p)
            3'd0:    c = CODE0;
            3'd1:    c = CODE1;
            3'd2:    c = CODE2;
            3'd3:    c = CODE3;
            3'd4:    c = CODE4;
            3'd5:    c = CODE5;
            default: c = CODE5;
        endcase
        return c;
    endfunction

    // BCD to 7-segment; only called for digits that matched the code.
    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] pos_q,   pos_d;
    logic [1:0] err_q,   err_d;
    logic [6:0] disp_q,  disp_d;
    logic       led_q,   led_d;
    logic [1:0] err_inc_s;

    assign err_inc_s = err_q + 2'd1;

    // Next-state and next-output computation for the entry sequence.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        err_d   = err_q;
        disp_d  = disp_q;
        led_d   = led_q;
        case (state_q)
            ST_ENTRY: begin
                if (!insere) begin
                    if (entrada == code_at(pos_q)) begin
                        if (pos_q == LAST_POS) begin
                            // The verdict replaces the echo of the last digit.
                            if (err_q == 2'd0) begin
                                state_d = ST_OK;
                                disp_d  = SEG_S;
                                led_d   = 1'b1;
                            end else begin
                                state_d = ST_PART;
                                disp_d  = SEG_P;
                                led_d   = 1'b0;
                            end
                        end else begin
                            pos_d  = pos_q + 3'd1;
                            disp_d = seg(entrada);
                        end
                    end else begin
                        // A wrong digit retries the same position.
                        err_d = err_inc_s;
                        if (err_inc_s >= MAX_ERR_L) begin
                            // The error that hits the limit shows "F" directly.
                            state_d = ST_FAIL;
                            disp_d  = SEG_F;
                            led_d   = 1'b0;
                        end else begin
                            disp_d = SEG_E;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_OK, ST_PART, ST_FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_FAIL;
                disp_d  = SEG_F;
                led_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ENTRY;
            pos_q   <= 3'd0;
            err_q   <= 2'd0;
            disp_q  <= SEG_DASH;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            disp_q  <= disp_d;
            led_q   <= led_d;
        end
    end

    assign display1 = disp_q;
    assign led      = led_q;

endmodule

// File: tb/tb_lock_top_module.sv
module tb_lock_top_module;

    logic       clk = 1'b0;
    logic       reset;
    logic       insere;
    logic [3:0] entrada;
    logic [6:0] display1;
    logic       led;

    lock_top_module dut (
        .clk      (clk),
        .reset    (reset),
        .insere   (insere),
        .entrada  (entrada),
        .display1 (display1),
        .led      (led)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: position, error count and verdict letter.
    int         code[6]    = '{5, 9, 0, 0, 6, 0};
    logic [6:0] segtab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         m_pos;
    int         m_err;
    byte        m_verdict;   // 0 while entering, else "S", "P" or "F"
    logic [6:0] exp_disp;
    logic       exp_led;
    bit         chk_en = 1'b0;

    task automatic model_reset();
        m_pos     = 0;
        m_err     = 0;
        m_verdict = 0;
        exp_disp  = 7'h40;
        exp_led   = 1'b0;
    endtask

    task automatic model_step(input logic ins, input logic [3:0] d);
        if (m_verdict == 0 && !ins) begin
            if (int'(d) == code[m_pos]) begin
                if (m_pos == 5) begin
                    m_verdict = (m_err == 0) ? "S" : "P";
                    exp_disp  = (m_err == 0) ? 7'h6D : 7'h73;
                    exp_led   = (m_err == 0);
                end else begin
                    exp_disp = segtab[d];
                    m_pos++;
                end
            end else begin
                m_err++;
                if (m_err >= 2) begin
                    m_verdict = "F";
                    exp_disp  = 7'h71;
                end else begin
                    exp_disp = 7'h79;
                end
            end
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (display1 !== exp_disp || led !== exp_led) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t: got disp=%h led=%b, want disp=%h led=%b",
                         $time, display1, led, exp_disp, exp_led);
            end
        end
    end

    // Literal check of both the DUT and the model.
    task automatic lit(input string name, input logic [6:0] d, input logic l);
        tests++;
        if (display1 !== d || led !== l) begin
            fails++;
            $display("FAIL %s: got disp=%h led=%b, want disp=%h led=%b",
                     name, display1, led, d, l);
        end
        tests++;
        if (exp_disp !== d || exp_led !== l) begin
            fails++;
            $display("FAIL model_%s: model disp=%h led=%b, want disp=%h led=%b",
                     name, exp_disp, exp_led, d, l);
        end
    endtask

    task automatic step(input logic ins, input logic [3:0] d);
        insere  = ins;
        entrada = d;
        @(posedge clk);
        model_step(ins, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        insere  = 1'b1;
        entrada = 4'd0;
        model_reset();
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        lit("reset_state", 7'h40, 1'b0);
        reset = 1'b1;

        // Full success: 5,9,0,0,6,0.
        do_reset();
        step(1'b0, 4'd5); lit("ok_d0", 7'h6D, 1'b0);
        step(1'b0, 4'd9); lit("ok_d1", 7'h6F, 1'b0);
        step(1'b0, 4'd0); lit("ok_d2", 7'h3F, 1'b0);
        step(1'b0, 4'd0); lit("ok_d3", 7'h3F, 1'b0);
        step(1'b0, 4'd6); lit("ok_d4", 7'h7D, 1'b0);
        step(1'b0, 4'd0); lit("ok_S",  7'h6D, 1'b1);
        step(1'b0, 4'd3); lit("ok_hold", 7'h6D, 1'b1);

        // One error: 5,8,9,0,0,6,0.
        do_reset();
        step(1'b0, 4'd5); lit("part_d0", 7'h6D, 1'b0);
        step(1'b0, 4'd8); lit("part_E",  7'h79, 1'b0);
        step(1'b0, 4'd9); lit("part_d1", 7'h6F, 1'b0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd6); lit("part_d4", 7'h7D, 1'b0);
        step(1'b0, 4'd0); lit("part_P",  7'h73, 1'b0);

        // Two errors: 5,8,8 then further entries ignored.
        do_reset();
        step(1'b0, 4'd5);
        step(1'b0, 4'd8); lit("fail_E", 7'h79, 1'b0);
        step(1'b0, 4'd8); lit("fail_F", 7'h71, 1'b0);
        step(1'b0, 4'd9); lit("fail_hold", 7'h71, 1'b0);
        step(1'b1, 4'd9); lit("fail_hold_ins", 7'h71, 1'b0);

        // Non-BCD entry is wrong; position is retried.
        do_reset();
        step(1'b0, 4'hC); lit("nonbcd_E", 7'h79, 1'b0);
        step(1'b0, 4'd5); lit("nonbcd_retry", 7'h6D, 1'b0);

        // Hold between digits.
        do_reset();
        step(1'b0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd9);
            lit("insere_hold", 7'h6D, 1'b0);
        end
        step(1'b0, 4'd9); lit("insere_release", 7'h6F, 1'b0);

        // Asynchronous reset between edges.
        step(1'b0, 4'd0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        lit("async_reset", 7'h40, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        step(1'b0, 4'd5); lit("restart_pos0", 7'h6D, 1'b0);

        // Randomized stimulus checked by the every-cycle compare.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       ins;
            logic [3:0] d;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                ins = ($urandom_range(0, 4) == 0);
                if (m_verdict == 0 && $urandom_range(0, 9) < 8)
                    d = 4'(code[m_pos]);
                else
                    d = 4'($urandom_range(0, 15));
                step(ins, d);
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
